// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// Requests are address-only; responses return in request order.
interface fetch_unit_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] addr;
    logic            rsp_valid;
    logic [ILEN-1:0] rsp_data;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// RV32I fetch front end: credit-limited pipelined requests to instruction memory,
// a first-word-fall-through instruction queue, and redirect flush with stale-response drop.
module fetch_unit #(
    parameter int          XLEN         = 32,
    parameter int          ILEN         = 32,
    parameter int          DEPTH        = 4,
    parameter logic [31:0] RESET_VECTOR = 32'h200
) (
    input  logic             clk,
    input  logic             rst,
    fetch_unit_if.master     io_imem,
    input  logic             i_redirect_valid,
    input  logic [XLEN-1:0]  i_redirect_target,
    output logic             o_redirect_misaligned,
    output logic             o_inst_valid,
    input  logic             i_inst_ready,
    output logic [ILEN-1:0]  o_inst_data,
    output logic [XLEN-1:0]  o_inst_pc
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int SUM_W = CW + 2;

    typedef logic [CW-1:0] cnt_t;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_rsp_pc;
    cnt_t            r_outstanding;
    cnt_t            r_drop_cnt;
    cnt_t            r_count;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic            r_redirect_misaligned;
    logic [ILEN-1:0] r_q_data [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];

    logic [SUM_W-1:0] w_credit_sum;
    logic             w_req_valid;
    logic             w_accept;
    logic             w_rsp_drop;
    logic             w_push;
    logic             w_inst_valid;
    logic             w_pop;
    cnt_t             w_drop_after;
    cnt_t             w_out_after;
    logic [XLEN-1:0]  w_target_aligned;

    // Every queue slot is pre-booked by a request in flight or a response still to be dropped,
    // which is why a push can never find the queue full.
    assign w_credit_sum = SUM_W'(r_outstanding) + SUM_W'(r_drop_cnt) + SUM_W'(r_count);
    assign w_req_valid  = w_credit_sum < SUM_W'(DEPTH);
    assign w_accept     = w_req_valid & io_imem.req_ready;

    assign w_rsp_drop   = io_imem.rsp_valid & (r_drop_cnt != '0);
    assign w_push       = io_imem.rsp_valid & (r_drop_cnt == '0);
    assign w_inst_valid = r_count != '0;
    assign w_pop        = w_inst_valid & i_inst_ready;

    assign w_drop_after     = r_drop_cnt - cnt_t'(w_rsp_drop);
    assign w_out_after      = r_outstanding - cnt_t'(w_push);
    assign w_target_aligned = {i_redirect_target[XLEN-1:2], 2'b00};

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc            <= XLEN'(RESET_VECTOR);
            r_rsp_pc              <= XLEN'(RESET_VECTOR);
            r_outstanding         <= '0;
            r_drop_cnt            <= '0;
            r_count               <= '0;
            r_rd_ptr              <= '0;
            r_wr_ptr              <= '0;
            r_redirect_misaligned <= 1'b0;
        end else begin
            r_redirect_misaligned <= i_redirect_valid & (|i_redirect_target[1:0]);
            if (i_redirect_valid) begin
                // Whatever is still owed by memory, including this cycle's accept, becomes stale.
                r_fetch_pc    <= w_target_aligned;
                r_rsp_pc      <= w_target_aligned;
                r_count       <= '0;
                r_rd_ptr      <= '0;
                r_wr_ptr      <= '0;
                r_outstanding <= '0;
                r_drop_cnt    <= w_drop_after + w_out_after + cnt_t'(w_accept);
            end else begin
                if (w_accept) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + XLEN'(4);
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count       <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
                r_outstanding <= w_out_after + cnt_t'(w_accept);
                r_drop_cnt    <= w_drop_after;
            end
        end
    end

    // NOTE: queue storage is not reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_data[r_wr_ptr] <= io_imem.rsp_data;
            r_q_pc[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    assign io_imem.req_valid     = w_req_valid;
    assign io_imem.addr          = r_fetch_pc;
    assign o_inst_valid          = w_inst_valid;
    assign o_inst_data           = r_q_data[r_rd_ptr];
    assign o_inst_pc             = r_q_pc[r_rd_ptr];
    assign o_redirect_misaligned = r_redirect_misaligned;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        w_push |-> (r_count != cnt_t'(DEPTH)));

    a_credit_bound: assert property (@(posedge clk) disable iff (rst)
        w_credit_sum <= SUM_W'(DEPTH));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model with programmable latency,
// hand-computed expected addresses, PCs and instruction words.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_misaligned;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

    fetch_unit #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .RESET_VECTOR(32'h200)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .io_imem               (bus),
        .i_redirect_valid      (redirect_valid),
        .i_redirect_target     (redirect_target),
        .o_redirect_misaligned (redirect_misaligned),
        .o_inst_valid          (inst_valid),
        .i_inst_ready          (inst_ready),
        .o_inst_data           (inst_data),
        .o_inst_pc             (inst_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    int          cyc    = 0;
    int          lat    = 1;
    int          n_acc  = 0;
    int          n_pop  = 0;
    int          n_vec  = 0;
    int          n_miss = 0;
    bit          last_pop;
    logic [31:0] last_pop_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, update the memory model after it,
    // and drive the next response at the following negedge.
    task automatic tick();
        bit          acc;
        bit          rsp;
        logic [31:0] a;
        pend_t       e;
        #1;
        acc         = bus.req_valid && bus.req_ready;
        a           = bus.addr;
        rsp         = bus.rsp_valid;
        last_pop    = inst_valid && inst_ready;
        last_pop_pc = inst_pc;
        @(posedge clk);
        cyc++;
        if (rst) begin
            pend.delete();
        end else begin
            if (rsp) void'(pend.pop_front());
            if (acc) begin
                n_acc++;
                e.addr = a;
                e.due  = cyc + lat;
                pend.push_back(e);
            end
            if (last_pop) n_pop++;
        end
        @(negedge clk);
        if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = pend[0].addr ^ 32'hAA;
        end else begin
            bus.rsp_valid = 1'b0;
            bus.rsp_data  = '0;
        end
    endtask

    task automatic do_reset(input string tag);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst   = 1'b0;
        n_acc = 0;
        n_pop = 0;
        check({tag, "_rst_req_valid"}, 32'(bus.req_valid), 32'd1);
        check({tag, "_rst_addr"}, bus.addr, 32'h200);
        check({tag, "_rst_inst_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_rst_misaligned"}, 32'(redirect_misaligned), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        inst_ready      = 1'b1;
        bus.req_ready   = 1'b1;
        bus.rsp_valid   = 1'b0;
        bus.rsp_data    = '0;

        // Streaming with 1-cycle memory.
        lat = 1;
        do_reset("t1");
        tick();
        check("t1_valid_e1", 32'(inst_valid), 32'd0);
        check("t1_addr_e1", bus.addr, 32'h204);
        tick();
        check("t1_valid_e2", 32'(inst_valid), 32'd1);
        check("t1_pc_e2", inst_pc, 32'h200);
        check("t1_data_e2", inst_data, 32'h2AA);
        check("t1_addr_e2", bus.addr, 32'h208);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("t1_stream_valid", 32'(inst_valid), 32'd1);
            check("t1_stream_pc", inst_pc, 32'h200 + 32'(4 * i));
            check("t1_stream_data", inst_data, (32'h200 + 32'(4 * i)) ^ 32'hAA);
        end

        // Decode stalled: credits cap the requests at DEPTH.
        inst_ready = 1'b0;
        do_reset("t2");
        for (int i = 0; i < 6; i++) tick();
        check("t2_req_valid_full", 32'(bus.req_valid), 32'd0);
        check("t2_accepts", 32'(n_acc), 32'd4);
        check("t2_head_pc", inst_pc, 32'h200);
        inst_ready = 1'b1;
        tick();
        check("t2_pc_after_pop", inst_pc, 32'h204);
        check("t2_req_resume", 32'(bus.req_valid), 32'd1);
        check("t2_addr_resume", bus.addr, 32'h210);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("t2_drain_pc", inst_pc, 32'h200 + 32'(4 * i));
        end

        // Memory not ready: address held, single accept.
        inst_ready    = 1'b0;
        bus.req_ready = 1'b0;
        do_reset("t3");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_hold_addr", bus.addr, 32'h200);
            check("t3_hold_valid", 32'(bus.req_valid), 32'd1);
        end
        check("t3_no_accept", 32'(n_acc), 32'd0);
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        check("t3_one_accept", 32'(n_acc), 32'd1);
        check("t3_addr_next", bus.addr, 32'h204);
        tick();
        check("t3_inst_valid", 32'(inst_valid), 32'd1);
        check("t3_inst_pc", inst_pc, 32'h200);
        tick();
        check("t3_still_one", 32'(n_acc), 32'd1);

        // 3-cycle memory, redirect with two requests in flight.
        lat           = 3;
        bus.req_ready = 1'b1;
        inst_ready    = 1'b1;
        do_reset("t4");
        tick();
        tick();
        bus.req_ready   = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h1000;
        tick();
        redirect_valid = 1'b0;
        bus.req_ready  = 1'b1;
        check("t4_accepts", 32'(n_acc), 32'd2);
        check("t4_addr_target", bus.addr, 32'h1000);
        check("t4_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
        check("t4_flushed", 32'(inst_valid), 32'd0);
        tick();
        check("t4_drop_e4", 32'(inst_valid), 32'd0);
        tick();
        check("t4_drop_e5", 32'(inst_valid), 32'd0);
        check("t4_drop_zero", 32'(dut.r_drop_cnt), 32'd0);
        tick();
        check("t4_wait_e6", 32'(inst_valid), 32'd0);
        tick();
        check("t4_valid_e7", 32'(inst_valid), 32'd1);
        check("t4_pc_e7", inst_pc, 32'h1000);
        check("t4_data_e7", inst_data, 32'h10AA);
        tick();
        check("t4_pc_e8", inst_pc, 32'h1004);

        // Misaligned redirect target.
        lat = 1;
        do_reset("t5");
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h2002;
        tick();
        redirect_valid = 1'b0;
        check("t5_misaligned_hi", 32'(redirect_misaligned), 32'd1);
        check("t5_addr_aligned", bus.addr, 32'h2000);
        tick();
        check("t5_misaligned_lo", 32'(redirect_misaligned), 32'd0);
        check("t5_stale_dropped", 32'(inst_valid), 32'd0);
        tick();
        check("t5_pc_target", inst_pc, 32'h2000);
        check("t5_valid_target", 32'(inst_valid), 32'd1);

        // Redirect coinciding with pop, response and accept.
        lat        = 2;
        inst_ready = 1'b0;
        do_reset("t6");
        tick();
        tick();
        tick();
        check("t6_head_pc", inst_pc, 32'h200);
        inst_ready      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        check("t6_popped", 32'(last_pop), 32'd1);
        check("t6_popped_pc", last_pop_pc, 32'h200);
        check("t6_flushed", 32'(inst_valid), 32'd0);
        check("t6_drop_cnt", 32'(dut.r_drop_cnt), 32'd2);
        check("t6_addr_target", bus.addr, 32'h3000);
        tick();
        tick();
        check("t6_still_empty", 32'(inst_valid), 32'd0);
        check("t6_pop_once", 32'(n_pop), 32'd1);
        tick();
        check("t6_valid_target", 32'(inst_valid), 32'd1);
        check("t6_pc_target", inst_pc, 32'h3000);

        // PC wrap at the top of the address space.
        lat        = 1;
        inst_ready = 1'b1;
        do_reset("t7");
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        check("t7_addr_fff8", bus.addr, 32'hFFFF_FFF8);
        tick();
        check("t7_addr_fffc", bus.addr, 32'hFFFF_FFFC);
        tick();
        check("t7_pc_fff8", inst_pc, 32'hFFFF_FFF8);
        check("t7_addr_wrap", bus.addr, 32'h0);
        tick();
        check("t7_pc_fffc", inst_pc, 32'hFFFF_FFFC);
        tick();
        check("t7_pc_wrap", inst_pc, 32'h0);
        check("t7_data_wrap", inst_data, 32'hAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation RV32I core. It replaces the single-cycle PC register and next-PC logic with a block that issues pipelined requests to instruction memory with arbitrary in-order latency. Returned instructions are buffered in a DEPTH-entry queue and presented to decode with a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

Parameters:
XLEN, 32, address/PC width.
ILEN, 32, instruction word width.
DEPTH, 4, queue entries and maximum requests in flight; power of 2, >= 2.
RESET_VECTOR, 32'h200, first fetch address after reset.

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
imem_req_valid  out  1  fetch request valid.
imem_req_ready  in  1  memory accepts the request this cycle.
imem_addr  out  XLEN  fetch address, word aligned.
imem_rsp_valid  in  1  response valid; responses return in request order, latency >= 1.
imem_rsp_data  in  ILEN  instruction word.
redirect_valid  in  1  one-cycle redirect from execute.
redirect_target  in  XLEN  new PC.
redirect_misaligned  out  1  registered pulse: the previous-cycle target had [1:0] != 0.
inst_valid  out  1  queue non-empty.
inst_ready  in  1  decode consumes the head entry.
inst_data  out  ILEN  head instruction.
inst_pc  out  XLEN  PC of the head instruction.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - fetch_pc=RESET_VECTOR, rsp_pc=RESET_VECTOR.
  - queue count=0, outstanding=0, drop_cnt=0, redirect_misaligned=0.
  - Outputs in the following cycle: imem_req_valid=1, imem_addr=RESET_VECTOR, inst_valid=0.
- Reset mid-operation discards all state. The memory side shares rst, so no pre-reset responses are delivered afterwards.
- Issue:
  - imem_req_valid = (outstanding + drop_cnt + count) < DEPTH.
  - Accept = imem_req_valid & imem_req_ready. On accept: fetch_pc += 4, outstanding += 1.
  - While ready is low, imem_addr is held stable. The only exception is a redirect, which may change imem_addr while valid is held; memory must treat the address as sampled on accept.
- Response:
  - If drop_cnt > 0: discard the response, drop_cnt -= 1.
  - Otherwise: push {rsp_pc, imem_rsp_data} to the queue, rsp_pc += 4, outstanding -= 1.
  - The credit rule guarantees the queue is never full on push. A push to a full queue is an assertion failure.
- Output:
  - First-word-fall-through. inst_data/inst_pc come from the head entry.
  - Pop when inst_valid & inst_ready.
  - Minimum latency is accept-to-inst_valid = memory latency + 1 cycle; for 1-cycle memory, first inst_valid is 2 cycles after reset release.
- Redirect (redirect_valid=1 at an edge), in this priority:
  - A pop in the same cycle completes; the entry is consumed.
  - A response in the same cycle is evaluated first, then the queue is flushed: count=0.
  - drop_cnt <= drop_cnt_after_rsp + outstanding_after_rsp + accept_this_cycle; outstanding <= 0.
  - fetch_pc and rsp_pc <= {redirect_target[XLEN-1:2], 2'b00}.
  - redirect_misaligned <= |redirect_target[1:0].
- Back-to-back redirects accumulate into drop_cnt. The credit rule bounds the total at DEPTH.
- Counters are $clog2(DEPTH)+1 bits wide. PCs wrap modulo 2^XLEN, so 0xFFFFFFFC + 4 = 0x0.
- No redirect: imem_rsp and inst ordering are strictly FIFO.

Test Plan:
- Reset release, 1-cycle memory returning addr^0xAA, inst_ready=1 -> imem_addr 0x200,0x204,0x208...; inst_valid first high 2 cycles after release with inst_pc=0x200, then one instruction per cycle.
- inst_ready=0, DEPTH=4 -> exactly 4 requests accepted (0x200..0x20C), then imem_req_valid=0; inst_ready=1 -> pops 0x200..0x20C in order, issue resumes at 0x210 the cycle after the first pop.
- imem_req_ready=0 for 3 cycles -> imem_addr holds 0x200, no outstanding increment; ready=1 -> accepted once.
- 3-cycle memory, 2 requests outstanding, redirect to 0x1000 -> both late responses discarded; next inst_pc=0x1000; drop_cnt returns to 0.
- Redirect to 0x2002 -> fetch from 0x2000, redirect_misaligned=1 for exactly one cycle.
- Redirect coinciding with a pop, a response, and a request accept -> popped entry delivered once, queue empty next cycle, drop_cnt = outstanding + 1, first post-redirect instruction is the target.
